// File: rtl/rotating_square_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rotating_square_ctrl
// Brief    : Single square glyph circling a row of seven-segment digits,
//            driving anodes and segments directly, with a lap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rotating_square_ctrl #(
    parameter int           DIGITS  = 4,
    parameter int           PW      = 28,
    parameter logic [7:0]   SEG_TOP = 8'b10011100,
    parameter logic [7:0]   SEG_BOT = 8'b11100010
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic                          cw,
    input  logic [PW-1:0]                 period,
    input  logic                          step,
    output logic [DIGITS-1:0]             an,
    output logic [7:0]                    sseg,
    output logic [$clog2(2*DIGITS)-1:0]   pos,
    output logic                          lap
);

    localparam int POS_W = $clog2(2*DIGITS);
    localparam logic [POS_W-1:0] c_last_pos = POS_W'(2*DIGITS-1);

    logic [PW-1:0]    r_cnt;
    logic [POS_W-1:0] r_pos;
    logic             r_lap;

    logic             w_tick;
    logic             w_adv;
    logic             w_wrap;
    logic [POS_W-1:0] w_pos_next;

    assign w_tick = en && (r_cnt >= period);
    assign w_adv  = w_tick || (!en && step);

    // Codes beyond the ring (non-power-of-two DIGITS) recover to 0 without a lap.
    always_comb begin
        w_pos_next = '0;
        w_wrap     = 1'b0;
        if (r_pos <= c_last_pos) begin
            if (cw) begin
                w_wrap     = (r_pos == '0);
                w_pos_next = w_wrap ? c_last_pos : r_pos - 1'b1;
            end else begin
                w_wrap     = (r_pos == c_last_pos);
                w_pos_next = w_wrap ? '0 : r_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_pos <= '0;
            r_lap <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_adv) begin
                r_pos <= w_pos_next;
            end
            r_lap <= w_adv && w_wrap;
        end
    end

    // Top half walks digits left to right, bottom half walks back.
    always_comb begin
        an   = '1;
        sseg = 8'hFF;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_pos == POS_W'(i)) begin
                an[i] = 1'b0;
                sseg  = SEG_TOP;
            end
            if (r_pos == c_last_pos - POS_W'(i)) begin
                an[i] = 1'b0;
                sseg  = SEG_BOT;
            end
        end
    end

    assign pos = r_pos;
    assign lap = r_lap;

endmodule
`default_nettype wire

// File: tb/tb_rotating_square_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotating_square_ctrl
// Brief    : Directed vector bench for rotating_square_ctrl (DIGITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotating_square_ctrl;

    localparam int DIGITS = 4;
    localparam int PW     = 28;
    localparam logic [7:0] c_top = 8'b10011100;
    localparam logic [7:0] c_bot = 8'b11100010;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          en      = 1'b0;
    logic          cw      = 1'b0;
    logic          step    = 1'b0;
    logic [PW-1:0] period  = '0;
    logic [3:0]    an;
    logic [7:0]    sseg;
    logic [2:0]    pos;
    logic          lap;

    int checks = 0;
    int errors = 0;

    logic [3:0] an_tab [8] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                               4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef struct {
        logic en;
        logic cw;
        logic step;
        int   exp_pos;
        logic exp_lap;
    } vec_t;

    vec_t tv [14];

    rotating_square_ctrl #(
        .DIGITS  (DIGITS),
        .PW      (PW),
        .SEG_TOP (c_top),
        .SEG_BOT (c_bot)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .cw      (cw),
        .period  (period),
        .step    (step),
        .an      (an),
        .sseg    (sseg),
        .pos     (pos),
        .lap     (lap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int p, input logic l);
        chk({tag, " pos"}, 32'(pos), 32'(p));
        chk({tag, " an"}, 32'(an), 32'(an_tab[p]));
        chk({tag, " sseg"}, 32'(sseg), 32'((p < DIGITS) ? c_top : c_bot));
        chk({tag, " lap"}, 32'(lap), 32'(l));
    endtask

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        en      = 1'b0;
        step    = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_pos("reset", 0, 1'b0);
        clk1();
        reset_n = 1'b1;
    endtask

    initial begin
        tv[0]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b1, 2, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 3, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 4, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 5, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 6, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 7, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 0, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 7, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 6, 1'b0};
        tv[10] = '{1'b0, 1'b1, 1'b0, 6, 1'b0};
        tv[11] = '{1'b1, 1'b1, 1'b1, 6, 1'b0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 6, 1'b0};
        tv[13] = '{1'b0, 1'b0, 1'b1, 7, 1'b0};

        // Power-on reset, asserted between clock edges
        #2 reset_n = 1'b0;
        #1 chk_pos("por", 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single-step table, large period so en=1 never ticks
        period = 28'd1000;
        for (int i = 0; i < 14; i++) begin
            en   = tv[i].en;
            cw   = tv[i].cw;
            step = tv[i].step;
            clk1();
            chk_pos($sformatf("vec%0d", i), tv[i].exp_pos, tv[i].exp_lap);
        end
        step = 1'b0;

        // Mid-run asynchronous reset
        period = '0;
        cw     = 1'b0;
        en     = 1'b1;
        clk1();
        chk_pos("run_pre0", 0, 1'b1);
        clk1();
        chk_pos("run_pre1", 1, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_pos("mid_reset", 0, 1'b0);
        en = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Counter-clockwise free run, period=2
        period = 28'd2;
        cw     = 1'b0;
        en     = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 2; j++) begin
                clk1();
                chk_pos($sformatf("ccw_wait%0d_%0d", k, j), k - 1, 1'b0);
            end
            clk1();
            chk_pos($sformatf("ccw_adv%0d", k), k % 8, k == 8);
        end

        // Clockwise from 0 with a direction flip at pos 5
        do_reset();
        period = '0;
        cw     = 1'b1;
        en     = 1'b1;
        clk1(); chk_pos("cw7", 7, 1'b1);
        clk1(); chk_pos("cw6", 6, 1'b0);
        clk1(); chk_pos("cw5", 5, 1'b0);
        cw = 1'b0;
        clk1(); chk_pos("flip6", 6, 1'b0);
        clk1(); chk_pos("flip7", 7, 1'b0);
        clk1(); chk_pos("flip0", 0, 1'b1);

        // Freeze holds the prescaler, then a period drop below cnt
        do_reset();
        period = 28'd100;
        en     = 1'b1;
        repeat (95) clk1();
        chk_pos("cnt95", 0, 1'b0);
        en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            clk1();
            chk_pos($sformatf("frz%0d", j), 0, 1'b0);
        end
        en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            clk1();
            chk_pos($sformatf("resume%0d", j), 0, 1'b0);
        end
        clk1();
        chk_pos("resume_tick", 1, 1'b0);
        repeat (50) clk1();
        period = 28'd10;
        clk1();
        chk_pos("drop_tick", 2, 1'b0);
        for (int j = 0; j < 10; j++) begin
            clk1();
            chk_pos($sformatf("p10_wait%0d", j), 2, 1'b0);
        end
        clk1();
        chk_pos("p10_tick", 3, 1'b0);
        period = '0;
        clk1(); chk_pos("p0_a", 4, 1'b0);
        clk1(); chk_pos("p0_b", 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
